// File: rtl/spi_master.sv
// spi_master: single-byte SPI master, modes 0-3, MSB first, programmable half-bit period.
// Define SPI_MASTER_LOOPBACK_EN to feed the receive shifter from MOSI instead of i_SPI_MISO.
module spi_master #(
   parameter int SPI_MODE          = 0,
   parameter int CLKS_PER_HALF_BIT = 2
) (
   input  logic       i_Clk,
   input  logic       i_Rst_L,
   input  logic [7:0] i_TX_Byte,
   input  logic       i_TX_DV,
   output logic       o_TX_Ready,
   output logic       o_RX_DV,
   output logic [7:0] o_RX_Byte,
   output logic       o_SPI_Clk,
   input  logic       i_SPI_MISO,
   output logic       o_SPI_MOSI
);
   localparam logic [0:0]    IDLE      = 1'b0;
   localparam logic [0:0]    SHIFT     = 1'b1;
   localparam logic          CPOL      = (SPI_MODE == 2) || (SPI_MODE == 3);
   localparam logic          CPHA      = (SPI_MODE == 1) || (SPI_MODE == 3);
   localparam int            CW        = $clog2(CLKS_PER_HALF_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_HALF_BIT - 1);

   logic [0:0]    r_state;
   logic [CW-1:0] r_clk_cnt;
   logic [4:0]    r_edge_cnt;
   logic [7:0]    r_tx_byte;
   logic [6:0]    r_rx_shift;
   logic          r_tx_ready;
   logic          r_rx_dv;
   logic [7:0]    r_rx_byte;
   logic          r_spi_clk;
   logic          r_mosi;

   logic       w_edge;
   logic       w_lead;
   logic       w_trail;
   logic       w_drive;
   logic       w_sample;
   logic [2:0] w_bit_idx;
   logic       w_miso;

`ifdef SPI_MASTER_LOOPBACK_EN
   logic w_unused_miso;
   assign w_unused_miso = i_SPI_MISO;
   assign w_miso        = r_mosi;
`else
   assign w_miso = i_SPI_MISO;
`endif

   assign w_edge   = (r_state == SHIFT) && (r_edge_cnt != 5'd0) && (r_clk_cnt == HALF_LAST);
   assign w_lead   = w_edge && (r_spi_clk == CPOL);
   assign w_trail  = w_edge && (r_spi_clk != CPOL);
   // in CPHA=0 the 16th (trailing) edge has no bit left to drive
   assign w_drive  = CPHA ? w_lead : (w_trail && (r_edge_cnt != 5'd1));
   assign w_sample = CPHA ? w_trail : w_lead;
   // edge count 16..1 maps onto bit 7..0 for both phases: bit = count/2 - 1
   assign w_bit_idx = 3'(r_edge_cnt[4:1] - 4'd1);

   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_state    <= IDLE;
         r_clk_cnt  <= '0;
         r_edge_cnt <= 5'd0;
         r_tx_byte  <= 8'h00;
         r_rx_shift <= 7'h00;
         r_tx_ready <= 1'b0;
         r_rx_dv    <= 1'b0;
         r_rx_byte  <= 8'h00;
         r_spi_clk  <= CPOL;
         r_mosi     <= 1'b0;
      end else begin
         r_rx_dv <= 1'b0;
         if (r_state == IDLE) begin
            r_tx_ready <= ~(i_TX_DV & r_tx_ready);
            if (i_TX_DV && r_tx_ready) begin
               r_state    <= SHIFT;
               r_tx_byte  <= i_TX_Byte;
               r_edge_cnt <= 5'd16;
               r_clk_cnt  <= '0;
               if (!CPHA) r_mosi <= i_TX_Byte[7];
            end
         end else if (r_edge_cnt == 5'd0) begin
            r_state    <= IDLE;
            r_tx_ready <= 1'b1;
         end else begin
            r_clk_cnt <= (r_clk_cnt == HALF_LAST) ? '0 : r_clk_cnt + 1'b1;
            if (w_edge) begin
               r_spi_clk  <= ~r_spi_clk;
               r_edge_cnt <= r_edge_cnt - 5'd1;
            end
            if (w_drive) r_mosi <= r_tx_byte[w_bit_idx];
            if (w_sample) r_rx_shift <= {r_rx_shift[5:0], w_miso};
            if (w_sample && (r_edge_cnt <= 5'd2)) begin
               r_rx_byte <= {r_rx_shift, w_miso};
               r_rx_dv   <= 1'b1;
            end
         end
      end
   end

   assign o_TX_Ready = r_tx_ready;
   assign o_RX_DV    = r_rx_dv;
   assign o_RX_Byte  = r_rx_byte;
   assign o_SPI_Clk  = r_spi_clk;
   assign o_SPI_MOSI = r_mosi;
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: four spi_master instances (modes 0-3) checked cycle by cycle against a timing model.
module tb_spi_master;
   logic clk = 1'b0;
   int tests = 0;
   int fails = 0;
`ifdef SPI_MASTER_LOOPBACK_EN
   localparam bit LB = 1'b1;
`else
   localparam bit LB = 1'b0;
`endif

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s mode%0d: got %0h expected %0h at %0t", nm, g, act, exp, $time);
      end
   endtask

   for (genvar g = 0; g < 4; g++) begin : gi
      localparam int HB   = (g == 3) ? 4 : (g == 1) ? 3 : 2;
      localparam bit TIE  = (g == 0) || (g == 3);
      localparam bit CPOL = (g >= 2);
      localparam bit CPHA = (g % 2) == 1;
      localparam int SMP  = CPHA ? 16 : 15;  // SPI edge number of the 8th MISO sample
      logic rst_n = 1'b0;
      logic dv = 1'b0;
      logic miso = 1'b0;
      logic done = 1'b0;
      logic [7:0] txb = 8'h00;
      logic rdy, rxdv, sclk, mosi;
      logic [7:0] rxb;
      logic [7:0] tq[$];
      logic [7:0] pq[$];
      int gq[$];
      int lq[$];
      int aq[$];

      spi_master #(.SPI_MODE(g), .CLKS_PER_HALF_BIT(HB)) u_dut (
         .i_Clk(clk), .i_Rst_L(rst_n), .i_TX_Byte(txb), .i_TX_DV(dv), .o_TX_Ready(rdy),
         .o_RX_DV(rxdv), .o_RX_Byte(rxb), .o_SPI_Clk(sclk),
         .i_SPI_MISO(TIE ? mosi : miso), .o_SPI_MOSI(mosi));

      // act: 0 plain, 1 reset after 5 edges, 2 inject 8'hFF strobe mid-transfer
      task automatic plan(input logic [7:0] t, input logic [7:0] p, input int gap, input int lit, input int act);
         tq.push_back(t);
         pq.push_back(p);
         gq.push_back(gap);
         lq.push_back(lit);
         aq.push_back(act);
      endtask

      initial begin
         logic busy, mrdy, mmosi, msclk, prev;
         logic [7:0] mtx, mrxb, mpat, want;
         int c, n, s, edges, dvc, wcnt, lit, act;
         busy = 1'b0; mrdy = 1'b0; mmosi = 1'b0; msclk = CPOL; mrxb = 8'h00;
         mtx = 8'h00; mpat = 8'h00; want = 8'h00;
         c = 0; n = 0; s = 0; edges = 0; dvc = 0; wcnt = 0; lit = -1; act = 0;
         if (g == 0) plan(8'hA5, 8'h00, 1, 8'hA5, 0);
         if (g == 1 || g == 2) plan(8'h96, 8'h3C, 1, LB ? 8'h96 : 8'h3C, 0);
         if (g == 3) begin
            plan(8'hC1, 8'h00, 2, 8'hC1, 0);
            plan(8'hBE, 8'h00, 0, 8'hBE, 0);
            plan(8'hEF, 8'h00, 0, 8'hEF, 0);
         end
         plan(8'h55, 8'h55, 1, 8'h55, 2);
         plan(8'h5A, 8'hA3, 0, -1, 1);
         plan(8'h81, 8'h81, 1, 8'h81, 0);
         for (int i = 0; i < 10; i++) plan(8'($urandom), 8'($urandom), $urandom_range(0, 3), -1, 0);
         repeat (3) @(posedge clk);
         #1;
         chk("reset_ready", g, rdy, 0);
         chk("reset_rx_dv", g, rxdv, 0);
         chk("reset_rx_byte", g, rxb, 8'h00);
         chk("reset_mosi", g, mosi, 0);
         chk("reset_sclk", g, sclk, CPOL);
         rst_n = 1'b1;
         prev = sclk;
         for (int cyc = 0; cyc < 20000; cyc++) begin
            @(posedge clk);
            #1;
            if (busy) begin
               c++;
               if (c == 16 * HB + 1) begin
                  busy = 1'b0;
                  mrdy = 1'b1;
                  chk("edge_count", g, edges, 16);
                  chk("rx_dv_count", g, dvc, 1);
                  if (lit >= 0) chk("rx_literal", g, rxb, lit);
               end
            end else if (mrdy && dv) begin
               busy = 1'b1; mrdy = 1'b0; c = 0; edges = 0; dvc = 0; wcnt = 0;
               mtx = txb; mpat = pq[0]; lit = lq[0]; act = aq[0];
               tq.delete(0); pq.delete(0); gq.delete(0); lq.delete(0); aq.delete(0);
               want = (TIE || LB) ? mtx : mpat;
            end else mrdy = 1'b1;
            if (busy) begin
               n = (c / HB > 16) ? 16 : c / HB;
               msclk = CPOL ^ n[0];
               if (!CPHA) mmosi = mtx[(n / 2 > 7) ? 0 : 7 - n / 2];
               else if (n > 0) mmosi = mtx[8 - (n + 1) / 2];
            end else msclk = CPOL;
            chk("tx_ready", g, rdy, mrdy);
            chk("spi_clk", g, sclk, msclk);
            chk("mosi", g, mosi, mmosi);
            if (busy && sclk !== prev) edges++;
            prev = sclk;
            if (rxdv === 1'b1) begin
               chk("rx_dv_timing", g, busy && c >= SMP * HB, 1);
               dvc++;
               mrxb = want;
            end
            chk("rx_byte", g, rxb, mrxb);
            if (busy && act == 1 && c == 5 * HB) begin
               rst_n = 1'b0;
               #1;
               busy = 1'b0; mrdy = 1'b0; mmosi = 1'b0; mrxb = 8'h00;
               chk("abort_ready", g, rdy, 0);
               chk("abort_rx_byte", g, rxb, 8'h00);
               chk("abort_mosi", g, mosi, 0);
               chk("abort_sclk", g, sclk, CPOL);
               repeat (2) @(posedge clk);
               #1;
               chk("abort_rx_dv", g, rxdv, 0);
               rst_n = 1'b1;
               dv = 1'b0;
               prev = sclk;
               continue;
            end
            miso = 1'($urandom);
            if (busy) begin
               dv = (act == 2 && c == 8 * HB) || ($urandom_range(0, 3) == 0);
               txb = (act == 2 && c == 8 * HB) ? 8'hFF : 8'($urandom);
               s = (c + 1) / HB;
               // MISO carries the pattern only at the edge where this mode must sample it
               if ((c + 1) % HB == 0 && s <= 16 && (s % 2) == (CPHA ? 0 : 1))
                  miso = mpat[7 - (s - 1) / 2];
            end else begin
               dv = mrdy && tq.size() > 0 && wcnt >= gq[0];
               if (dv) txb = tq[0];
               if (mrdy) wcnt++;
            end
            if (!busy && mrdy && tq.size() == 0) break;
         end
         chk("all_transfers_done", g, tq.size() == 0 && !busy, 1);
         done = 1'b1;
      end
   end

   initial begin
      for (int t = 0; t < 50000; t++) begin
         @(posedge clk);
         if (gi[0].done && gi[1].done && gi[2].done && gi[3].done) break;
      end
      chk("finish_timeout", 0, gi[0].done & gi[1].done & gi[2].done & gi[3].done, 1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
